// File: rtl/axis_reg_slice_pkg.sv
// Shared types and constants for the AXI-Stream register slice.
package axis_reg_slice_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } slice_state_t;

  localparam string MODE_BOTH = "BOTH";
  localparam string MODE_FWD  = "FWD";
  localparam string MODE_BWD  = "BWD";

  function automatic logic [1:0] state_fill(input slice_state_t s);
    case (s)
      EMPTY:   return 2'd0;
      BUSY:    return 2'd1;
      FULL:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/axis_slice_reg.sv
// Width-generic payload register with load enable; payload is deliberately not reset.
module axis_slice_reg #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] data_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      data_q <= d_i;
    end else begin
      data_q <= data_q;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/axis_reg_slice.sv
// AXI-Stream register slice: BOTH (2-entry skid, both paths flopped), FWD (data/valid
// flopped) or BWD (tready flopped). Reports beats held inside the slice on fill_o.
module axis_reg_slice
  import axis_reg_slice_pkg::*;
#(
  parameter string MODE    = "BOTH",
  parameter int    DSIZE   = 32,
  parameter int    KSIZE   = 4,
  parameter int    USIZE   = 1,
  parameter int    M_DSIZE = DSIZE
) (
  input  logic               aclk_i,
  input  logic               aresetn_i,
  input  logic [DSIZE-1:0]   s_tdata_i,
  input  logic [KSIZE-1:0]   s_tkeep_i,
  input  logic [USIZE-1:0]   s_tuser_i,
  input  logic               s_tlast_i,
  input  logic               s_tvalid_i,
  output logic               s_tready_o,
  output logic [M_DSIZE-1:0] m_tdata_o,
  output logic [KSIZE-1:0]   m_tkeep_o,
  output logic [USIZE-1:0]   m_tuser_o,
  output logic               m_tlast_o,
  output logic               m_tvalid_o,
  input  logic               m_tready_i,
  output logic [1:0]         fill_o
);

  localparam int PW = DSIZE + KSIZE + USIZE + 1;

  logic [PW-1:0] in_payload_s;
  logic [PW-1:0] out_payload_s;

  assign in_payload_s = {s_tlast_i, s_tuser_i, s_tkeep_i, s_tdata_i};
  assign {m_tlast_o, m_tuser_o, m_tkeep_o, m_tdata_o} = out_payload_s;

  if (M_DSIZE != DSIZE) begin : g_width_err
    $error("axis_reg_slice: slave DSIZE %0d differs from master DSIZE %0d", DSIZE, M_DSIZE);
  end

  if (MODE == MODE_BOTH) begin : g_both
    slice_state_t  state_q, state_d;
    logic          ready_q, ready_d;
    logic          valid_q, valid_d;
    logic [1:0]    fill_q, fill_d;
    logic          in_xfer_s, out_xfer_s;
    logic          out_en_s, skid_en_s, out_sel_skid_s;
    logic [PW-1:0] out_d_s, out_q_s, skid_q_s;

    // Handshakes use the flopped ready/valid so the post-reset ready=0 cycle is honoured.
    assign in_xfer_s  = s_tvalid_i & ready_q;
    assign out_xfer_s = valid_q & m_tready_i;

    // State register
    always_ff @(posedge aclk_i or negedge aresetn_i) begin
      if (!aresetn_i) begin
        state_q <= EMPTY;
      end else begin
        state_q <= state_d;
      end
    end

    // Next-state logic
    always_comb begin
      state_d = state_q;
      case (state_q)
        EMPTY: begin
          if (in_xfer_s) state_d = BUSY;
          else           state_d = EMPTY;
        end
        BUSY: begin
          if (in_xfer_s && !out_xfer_s)      state_d = FULL;
          else if (!in_xfer_s && out_xfer_s) state_d = EMPTY;
          else                               state_d = BUSY;
        end
        FULL: begin
          if (out_xfer_s) state_d = BUSY;
          else            state_d = FULL;
        end
        default: state_d = EMPTY;
      endcase
    end

    // Output decode: register load enables and next values of the flopped handshake outputs
    always_comb begin
      out_en_s       = 1'b0;
      skid_en_s      = 1'b0;
      out_sel_skid_s = 1'b0;
      case (state_q)
        EMPTY: out_en_s = in_xfer_s;
        BUSY: begin
          out_en_s  = in_xfer_s & out_xfer_s;
          skid_en_s = in_xfer_s & ~out_xfer_s;
        end
        FULL: begin
          out_en_s       = out_xfer_s;
          out_sel_skid_s = 1'b1;
        end
        default: out_en_s = 1'b0;
      endcase
      ready_d = (state_d != FULL);
      valid_d = (state_d != EMPTY);
      fill_d  = state_fill(state_d);
    end

    // Flopped handshake and occupancy outputs
    always_ff @(posedge aclk_i or negedge aresetn_i) begin
      if (!aresetn_i) begin
        ready_q <= 1'b0;
        valid_q <= 1'b0;
        fill_q  <= 2'd0;
      end else begin
        ready_q <= ready_d;
        valid_q <= valid_d;
        fill_q  <= fill_d;
      end
    end

    assign out_d_s = out_sel_skid_s ? skid_q_s : in_payload_s;

    axis_slice_reg #(.W(PW)) u_out_reg (
      .clk_i (aclk_i),
      .en_i  (out_en_s),
      .d_i   (out_d_s),
      .q_o   (out_q_s)
    );

    axis_slice_reg #(.W(PW)) u_skid_reg (
      .clk_i (aclk_i),
      .en_i  (skid_en_s),
      .d_i   (in_payload_s),
      .q_o   (skid_q_s)
    );

    assign s_tready_o    = ready_q;
    assign m_tvalid_o    = valid_q;
    assign fill_o        = fill_q;
    assign out_payload_s = out_q_s;
  end else if (MODE == MODE_FWD) begin : g_fwd
    logic          valid_q, valid_d;
    logic          ready_s, load_s;
    logic [PW-1:0] out_q_s;

    assign ready_s = m_tready_i | ~valid_q;
    assign load_s  = s_tvalid_i & ready_s;

    // Output register keeps its beat until downstream takes it
    always_comb begin
      if (load_s) begin
        valid_d = 1'b1;
      end else begin
        valid_d = valid_q & ~m_tready_i;
      end
    end

    // Valid flop
    always_ff @(posedge aclk_i or negedge aresetn_i) begin
      if (!aresetn_i) begin
        valid_q <= 1'b0;
      end else begin
        valid_q <= valid_d;
      end
    end

    axis_slice_reg #(.W(PW)) u_out_reg (
      .clk_i (aclk_i),
      .en_i  (load_s),
      .d_i   (in_payload_s),
      .q_o   (out_q_s)
    );

    assign s_tready_o    = ready_s;
    assign m_tvalid_o    = valid_q;
    assign fill_o        = {1'b0, valid_q};
    assign out_payload_s = out_q_s;
  end else if (MODE == MODE_BWD) begin : g_bwd
    logic          skid_valid_q, skid_valid_d;
    logic          ready_q;
    logic          in_xfer_s, skid_en_s;
    logic [PW-1:0] skid_q_s;

    assign in_xfer_s = s_tvalid_i & ready_q;

    // A passed-through beat that downstream refuses is parked in the skid register
    always_comb begin
      skid_en_s = in_xfer_s & ~skid_valid_q & ~m_tready_i;
      if (skid_valid_q) begin
        skid_valid_d = ~m_tready_i;
      end else begin
        skid_valid_d = skid_en_s;
      end
    end

    // Skid occupancy and flopped ready
    always_ff @(posedge aclk_i or negedge aresetn_i) begin
      if (!aresetn_i) begin
        skid_valid_q <= 1'b0;
        ready_q      <= 1'b0;
      end else begin
        skid_valid_q <= skid_valid_d;
        ready_q      <= ~skid_valid_d;
      end
    end

    axis_slice_reg #(.W(PW)) u_skid_reg (
      .clk_i (aclk_i),
      .en_i  (skid_en_s),
      .d_i   (in_payload_s),
      .q_o   (skid_q_s)
    );

    assign s_tready_o    = ready_q;
    assign m_tvalid_o    = skid_valid_q | (s_tvalid_i & ready_q);
    assign fill_o        = {1'b0, skid_valid_q};
    assign out_payload_s = skid_valid_q ? skid_q_s : in_payload_s;
  end else begin : g_bad_mode
    $error("axis_reg_slice: unsupported MODE %s", MODE);
    assign s_tready_o    = 1'b0;
    assign m_tvalid_o    = 1'b0;
    assign fill_o        = 2'd0;
    assign out_payload_s = '0;
  end

endmodule
